bmem_arbiter: RTL and testbench
===============================

# bmem_arbiter

Shares the single burst-memory port (`bmem_*`) of `cpu` between the instruction cache and the data cache. Each cache issues whole 256-bit line requests; the arbiter grants one requester at a time and serialises the line into four 64-bit beats. It collects read beats into a line buffer and returns the line with a one-cycle response pulse. It sits between the two caches and the `cpu` top-level `bmem_*` ports.

## Interface
Parameters:
- none; line = 256 bits, beat = 64 bits, 4 beats per line (fixed).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_addr`  in  32  I-cache line address; bits [4:0] ignored.
- `i_read`  in  1  I-cache line read request; held until `i_resp`.
- `i_rdata`  out  256  line returned to I-cache; valid with `i_resp`.
- `i_resp`  out  1  one-cycle completion pulse to I-cache.
- `d_addr`  in  32  D-cache line address; bits [4:0] ignored.
- `d_read`  in  1  D-cache line read request.
- `d_write`  in  1  D-cache line write-back request.
- `d_wdata`  in  256  write-back line; held with `d_write`.
- `d_rdata`  out  256  line returned to D-cache.
- `d_resp`  out  1  one-cycle completion pulse to D-cache.
- `bmem_addr`  out  32  line address `{addr[31:5],5'b0}`.
- `bmem_read`  out  1  read command.
- `bmem_write`  out  1  write beat valid.
- `bmem_wdata`  out  64  write beat data.
- `bmem_ready`  in  1  memory accepts the command/beat this cycle.
- `bmem_raddr`  in  32  address tag of the returning read beat.
- `bmem_rdata`  in  64  read beat data.
- `bmem_rvalid`  in  1  read beat valid.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP.
- IDLE: sample requests and latch the grant (I or D), the aligned address and, for a write, `d_wdata`. Clear the 2-bit beat counter. Go to RD_REQ for a read, WR_BURST for a write, or stay in IDLE if there are no requests.
- RD_REQ: drive `bmem_read`=1 and `bmem_addr`. Go to RD_WAIT in the cycle `bmem_ready`=1; otherwise hold.
- RD_WAIT: on `bmem_rvalid`=1 with `bmem_raddr` equal to the latched address, store `bmem_rdata` into line bits [64k+63:64k] and increment k. Ignore beats with a mismatched tag. After beat k=3, go to RESP.
- WR_BURST: drive `bmem_write`=1, `bmem_addr`, and `bmem_wdata` = latched line beat k. Increment k only on `bmem_ready`=1. Once beat 3 is accepted, go to RESP.
- RESP: pulse `i_resp` or `d_resp` for exactly one cycle, according to the grant. `i_rdata`/`d_rdata` hold the assembled line (for a write, contents are don't-care). Then go to IDLE.
- Requester contract:
  - Address, command and `d_wdata` stay stable until resp.
  - The requester deasserts its command, or presents a new one, in the cycle after resp.
  - `d_read` and `d_write` are never asserted together; this is checked by a simulation assertion.
- `bmem_read` and `bmem_write` are never both 1.
- `bmem_rvalid` arriving in any state other than RD_WAIT is dropped.

## Timing
- Reset values:
  - state = IDLE, counter = 0, grant = D, round-robin pointer = D.
  - All outputs 0, including `bmem_addr`, `bmem_wdata`, `i_rdata` and `d_rdata`.
- Reset mid-burst aborts the transaction immediately. Stale read beats after reset are dropped in IDLE. No resp is issued for the aborted request.
- Request seen in IDLE at cycle t leads to the bmem command at cycle t+1.
- Read latency: resp occurs 1 cycle after the 4th matching beat. With zero memory delay and back-to-back beats, resp comes at t+1+1+(memory latency)+4.
- Write with `bmem_ready` constantly 1: beats occupy cycles t+1..t+4, and resp comes at t+5.
- Minimum gap: one IDLE cycle between resp and the next command.

## Configuration
- `BMEM_ARB_RR_EN` defined: round-robin arbitration.
  - When I and D request in the same IDLE cycle, the requester not granted last wins.
  - The pointer updates on every grant.
- Not defined: fixed priority. D-cache always wins simultaneous requests, and the pointer logic is absent.
- Single requesters behave identically in both builds.

## Test plan
- I-read 0x0000_1024, `bmem_ready`=1, beats 0x11..,0x22..,0x33..,0x44.. -> `bmem_addr`=0x0000_1020 and `i_resp` with `i_rdata` = {0x44..,0x33..,0x22..,0x11..}.
- D-write 0x8000_0040 with `bmem_ready` toggling 1,0,1,0,... -> 4 beats emitted in order, each held while ready=0, `d_resp` once after the 4th accept.
- Simultaneous `i_read` and `d_read` twice in a row:
  - Without `BMEM_ARB_RR_EN`: D, then D.
  - With it: D, then I.
- During RD_WAIT, inject a beat with a wrong `bmem_raddr` -> it is ignored. The line is assembled only from the 4 matching beats.
- Assert `rst` after beat 2 of a read -> outputs 0 and state IDLE next cycle. Remaining beats are dropped and no resp is issued.
- `bmem_ready`=0 for 10 cycles in RD_REQ -> `bmem_read` and `bmem_addr` stay stable throughout, and the command is accepted on the first ready cycle.

Source files
------------

// File: rtl/bmem_arbiter.sv
// Arbitrates the single burst-memory port between I-cache and D-cache; lines move as four 64-bit beats.
// Optional feature: define BMEM_ARB_RR_EN for round-robin arbitration (default is fixed D-cache priority).
module bmem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_addr,
  input  logic         i_read,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic [31:0]  d_addr,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_t;

  state_t       state;
  logic [1:0]   beat;
  logic [1:0]   beat_nxt;
  logic         grant_d;
  logic [255:0] line;
  logic         i_req;
  logic         d_req;
  logic         pick_d;
  logic         unused_addr_bits;

  assign i_req            = i_read;
  assign d_req            = d_read | d_write;
  assign beat_nxt         = beat + 2'd1;
  assign unused_addr_bits = ^{i_addr[4:0], d_addr[4:0]};

  // One buffer serves both directions: read beats are assembled here, write-back lines are latched here.
  assign i_rdata = line;
  assign d_rdata = line;

`ifdef BMEM_ARB_RR_EN
  logic prio_d;
  assign pick_d = d_req && (!i_req || prio_d);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= 2'd0;
      grant_d    <= 1'b1;
      line       <= '0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
`ifdef BMEM_ARB_RR_EN
      prio_d     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          beat <= 2'd0;
          if (i_req || d_req) begin
            grant_d <= pick_d;
`ifdef BMEM_ARB_RR_EN
            prio_d  <= !pick_d;
`endif
            if (pick_d) begin
              bmem_addr <= {d_addr[31:5], 5'b0};
              if (d_write) begin
                line       <= d_wdata;
                bmem_write <= 1'b1;
                bmem_wdata <= d_wdata[63:0];
                state      <= WR_BURST;
              end else begin
                bmem_read <= 1'b1;
                state     <= RD_REQ;
              end
            end else begin
              bmem_addr <= {i_addr[31:5], 5'b0};
              bmem_read <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Beats tagged for another line (e.g. left over from an earlier request) are skipped.
          if (bmem_rvalid && (bmem_raddr == bmem_addr)) begin
            line[{beat, 6'd0} +: 64] <= bmem_rdata;
            beat                     <= beat_nxt;
            if (beat == 2'd3) begin
              i_resp <= !grant_d;
              d_resp <= grant_d;
              state  <= RESP;
            end
          end
        end
        WR_BURST: begin
          if (bmem_ready) begin
            if (beat == 2'd3) begin
              bmem_write <= 1'b0;
              i_resp     <= !grant_d;
              d_resp     <= grant_d;
              state      <= RESP;
            end else begin
              beat       <= beat_nxt;
              bmem_wdata <= line[{beat_nxt, 6'd0} +: 64];
            end
          end
        end
        RESP: begin
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  d_cmd_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $error("d_read and d_write asserted together");
`endif

endmodule

// File: tb/tb_bmem_arbiter.sv
// Self-checking bench for bmem_arbiter: vector table, arbitration and reset-abort sequences, random traffic.
module tb_bmem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  i_addr = '0;
  logic         i_read = 1'b0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_addr = '0;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [255:0] d_wdata = '0;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready = 1'b0;
  logic [31:0]  bmem_raddr = '0;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_rvalid = 1'b0;

  int tests = 0;
  int fails = 0;

  bmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    bit           is_d;
    logic [31:0]  addr;
    logic [255:0] line;
    int           rdy;
    bit           bad;
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int j = 0; j < 8; j++) l[j*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    bmem_ready = 1'b0; bmem_rvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Requests a line, optionally stalls acceptance and injects a wrongly tagged beat, then checks the response.
  task automatic run_read(input bit is_d, input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [255:0] line, input int rdy_delay, input bit bad,
                          input string tag);
    if (is_d) begin d_read = 1'b1; d_addr = addr; end
    else begin i_read = 1'b1; i_addr = addr; end
    bmem_ready = 1'b0;
    tick();
    check({tag, ".cmd"}, {bmem_read, bmem_write, bmem_addr}, {2'b10, exp_addr});
    for (int c = 0; c < rdy_delay; c++) begin
      tick();
      check({tag, ".hold"}, {bmem_read, bmem_write, bmem_addr}, {2'b10, exp_addr});
    end
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    check({tag, ".accept"}, {bmem_read, bmem_write}, 2'b00);
    for (int k = 0; k < 4; k++) begin
      if (bad && k == 2) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = exp_addr ^ 32'h0000_0100;
        bmem_rdata  = ~line[k*64 +: 64];
        tick();
      end
      bmem_rvalid = 1'b1;
      bmem_raddr  = exp_addr;
      bmem_rdata  = line[k*64 +: 64];
      tick();
      if (k < 3) check({tag, ".early"}, {i_resp, d_resp}, 2'b00);
    end
    bmem_rvalid = 1'b0;
    check({tag, ".resp"}, {i_resp, d_resp}, is_d ? 2'b01 : 2'b10);
    check({tag, ".rdata"}, is_d ? d_rdata : i_rdata, line);
    if (is_d) d_read = 1'b0;
    else i_read = 1'b0;
    tick();
    check({tag, ".pulse"}, {i_resp, d_resp}, 2'b00);
  endtask

  // mode 0: ready always 1, mode 1: ready 1,0,1,0..., mode 2: random ready.
  task automatic run_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [255:0] line, input int mode, input string tag);
    int k = 0;
    int cyc = 0;
    bit r;
    d_write = 1'b1; d_addr = addr; d_wdata = line;
    bmem_ready = 1'b0;
    tick();
    check({tag, ".cmd"}, {bmem_read, bmem_write, bmem_addr}, {2'b01, exp_addr});
    while (k < 4 && cyc < 64) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      bmem_ready = r;
      check({tag, ".beat"}, {bmem_read, bmem_write, bmem_addr, bmem_wdata},
            {2'b01, exp_addr, line[k*64 +: 64]});
      tick();
      if (r) k++;
      cyc++;
    end
    bmem_ready = 1'b0;
    check({tag, ".beats_done"}, 256'(k), 256'd4);
    check({tag, ".resp"}, {bmem_write, i_resp, d_resp}, 3'b001);
    d_write = 1'b0;
    tick();
    check({tag, ".pulse"}, {i_resp, d_resp}, 2'b00);
  endtask

  initial begin
    logic [255:0] la;
    logic [255:0] lb;
    int           kind;

    vecs[0] = '{0, 0, 32'h0000_1024,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0, 32'h0000_1020};
    vecs[1] = '{1, 1, 32'h8000_0040,
                {64'hDDDD_0004_0000_0003, 64'hCCCC_0003_0000_0002,
                 64'hBBBB_0002_0000_0001, 64'hAAAA_0001_0000_0000}, 1, 0, 32'h8000_0040};
    vecs[2] = '{0, 1, 32'h1234_567F,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}, 0, 1, 32'h1234_5660};
    vecs[3] = '{0, 0, 32'hDEAD_BEEF,
                {64'h1, 64'h2, 64'h3, 64'h4}, 10, 0, 32'hDEAD_BEE0};
    vecs[4] = '{1, 1, 32'h0000_001F,
                {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0001, 64'h7}, 0, 0, 32'h0};

    // Reset state
    rst = 1'b1;
    tick();
    check("reset.ctl", {bmem_addr, bmem_read, bmem_write, bmem_wdata, i_resp, d_resp}, '0);
    check("reset.rdata", {i_rdata[127:0], d_rdata[127:0]}, '0);
    rst = 1'b0;
    tick();
    check("idle.ctl", {bmem_read, bmem_write, i_resp, d_resp}, 4'b0000);

    // Simultaneous requests, twice, from a fresh reset
    do_reset();
    la = rand_line();
    lb = rand_line();
    i_read = 1'b1; i_addr = 32'h0000_2000;
    d_read = 1'b1; d_addr = 32'h0000_3000;
    run_read(1'b1, 32'h0000_3000, 32'h0000_3000, la, 0, 1'b0, "arb1");
    d_read = 1'b1; d_addr = 32'h0000_3000;
`ifdef BMEM_ARB_RR_EN
    run_read(1'b0, 32'h0000_2000, 32'h0000_2000, lb, 0, 1'b0, "arb2");
`else
    run_read(1'b1, 32'h0000_3000, 32'h0000_3000, lb, 0, 1'b0, "arb2");
`endif
    i_read = 1'b0;
    d_read = 1'b0;

    // Vector table
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].wr)
        run_write(vecs[v].addr, vecs[v].exp_addr, vecs[v].line, vecs[v].rdy, $sformatf("vec%0d", v));
      else
        run_read(vecs[v].is_d, vecs[v].addr, vecs[v].exp_addr, vecs[v].line, vecs[v].rdy,
                 vecs[v].bad, $sformatf("vec%0d", v));
    end

    // Random traffic against the arithmetic reference (aligned address, line = beats in order)
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      a    = $urandom;
      la   = rand_line();
      kind = $urandom_range(0, 2);
      if (kind == 2)
        run_write(a, a & 32'hFFFF_FFE0, la, $urandom_range(0, 2), $sformatf("rnd%0d", n));
      else
        run_read(kind == 1, a, a & 32'hFFFF_FFE0, la, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    // Reset after two beats of a read: abort, drop the stale beats, no response
    la = rand_line();
    i_read = 1'b1; i_addr = 32'h0000_4008;
    tick();
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_4000; bmem_rdata = la[k*64 +: 64];
      tick();
    end
    bmem_rvalid = 1'b0;
    rst = 1'b1;
    i_read = 1'b0;
    #1;
    check("abort.ctl", {bmem_addr, bmem_read, bmem_write, bmem_wdata, i_resp, d_resp}, '0);
    check("abort.rdata", i_rdata, '0);
    tick();
    rst = 1'b0;
    for (int k = 2; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_4000; bmem_rdata = la[k*64 +: 64];
      tick();
      check("abort.stale", {i_resp, d_resp, bmem_read, bmem_write}, 4'b0000);
      check("abort.line", i_rdata, '0);
    end
    bmem_rvalid = 1'b0;
    tick();
    check("abort.quiet", {i_resp, d_resp, bmem_read, bmem_write}, 4'b0000);
    run_read(1'b0, 32'h0000_5010, 32'h0000_5000, rand_line(), 1, 1'b0, "post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
